// File: rtl/countdown_timer.sv
// Loadable down-counting timer with prescaler, one-shot/periodic modes and pause/cancel.
// Emits a registered single-cycle expire pulse when the tick count runs out.
module countdown_timer #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      periodic,
    input  logic                      pause,
    input  logic                      cancel,
    output logic                      busy,
    output logic                      expire,
    output logic [WIDTH-1:0]          remaining
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [WIDTH-1:0]          REM_ONE = WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PC_ONE  = PRESCALE_WIDTH'(1);

    state_e                    state_q,     state_d;
    logic [WIDTH-1:0]          remaining_q, remaining_d;
    logic [WIDTH-1:0]          reload_q,    reload_d;
    logic [PRESCALE_WIDTH-1:0] p_lat_q,     p_lat_d;
    logic [PRESCALE_WIDTH-1:0] pc_q,        pc_d;
    logic                      per_lat_q,   per_lat_d;
    logic                      expire_q,    expire_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            reload_q    <= '0;
            p_lat_q     <= '0;
            pc_q        <= '0;
            per_lat_q   <= 1'b0;
            expire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            reload_q    <= reload_d;
            p_lat_q     <= p_lat_d;
            pc_q        <= pc_d;
            per_lat_q   <= per_lat_d;
            expire_q    <= expire_d;
        end
    end

    // Priority: load > cancel > pause > tick step.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        reload_d    = reload_q;
        p_lat_d     = p_lat_q;
        pc_d        = pc_q;
        per_lat_d   = per_lat_q;
        expire_d    = 1'b0;
        if (load) begin
            reload_d  = load_value;
            p_lat_d   = prescale;
            per_lat_d = periodic;
            pc_d      = '0;
            if (load_value != '0) begin
                remaining_d = load_value;
                state_d     = RUN;
            end else begin
                remaining_d = '0;
                state_d     = IDLE;
                expire_d    = 1'b1;
            end
        end else if (cancel) begin
            state_d     = IDLE;
            remaining_d = '0;
            pc_d        = '0;
        end else if (state_q == RUN && !pause) begin
            if (pc_q != p_lat_q) begin
                pc_d = pc_q + PC_ONE;
            end else begin
                pc_d = '0;
                if (remaining_q > REM_ONE) begin
                    remaining_d = remaining_q - REM_ONE;
                end else begin
                    // Terminal tick: remaining==1 (0 cannot occur while running).
                    expire_d = 1'b1;
                    if (per_lat_q) begin
                        remaining_d = reload_q;
                    end else begin
                        remaining_d = '0;
                        state_d     = IDLE;
                    end
                end
            end
        end
    end

    always_comb begin
        busy      = (state_q == RUN);
        expire    = expire_q;
        remaining = remaining_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: table of per-cycle stimulus with expected
// outputs, routed through a scoreboard queue and compared one time unit after each edge.
module tb_countdown_timer;

    localparam int unsigned W  = 16;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          rst, load, periodic, pause, cancel;
    logic [W-1:0]  load_value;
    logic [PW-1:0] prescale;
    logic          busy, expire;
    logic [W-1:0]  remaining;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .prescale   (prescale),
        .periodic   (periodic),
        .pause      (pause),
        .cancel     (cancel),
        .busy       (busy),
        .expire     (expire),
        .remaining  (remaining)
    );

    typedef struct {
        string         tag;
        logic          rst, load;
        logic [W-1:0]  lv;
        logic [PW-1:0] ps;
        logic          per, pa, ca;
        logic          eb, ee;
        logic [W-1:0]  er;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(string tag, logic r, logic ld, logic [W-1:0] lv, logic [PW-1:0] ps,
                                logic per, logic pa, logic ca, logic eb, logic ee, logic [W-1:0] er);
        vec_t v;
        v.tag = tag; v.rst = r; v.load = ld; v.lv = lv; v.ps = ps;
        v.per = per; v.pa = pa; v.ca = ca; v.eb = eb; v.ee = ee; v.er = er;
        return v;
    endfunction

    function automatic void add(string tag, logic r, logic ld, logic [W-1:0] lv, logic [PW-1:0] ps,
                                logic per, logic pa, logic ca, logic eb, logic ee, logic [W-1:0] er);
        vecs.push_back(mk(tag, r, ld, lv, ps, per, pa, ca, eb, ee, er));
    endfunction

    function automatic void idle(string tag, logic eb, logic ee, logic [W-1:0] er);
        add(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, eb, ee, er);
    endfunction

    function automatic void hold(string tag, logic eb, logic ee, logic [W-1:0] er);
        add(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, eb, ee, er);
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; load = v.load; load_value = v.lv; prescale = v.ps;
        periodic = v.per; pause = v.pa; cancel = v.ca;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks += 3;
        if (busy !== e.eb) begin
            failures++;
            $display("FAIL %s busy: got %0b expected %0b", e.tag, busy, e.eb);
        end
        if (expire !== e.ee) begin
            failures++;
            $display("FAIL %s expire: got %0b expected %0b", e.tag, expire, e.ee);
        end
        if (remaining !== e.er) begin
            failures++;
            $display("FAIL %s remaining: got %0d expected %0d", e.tag, remaining, e.er);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_value = '0; prescale = '0;
        periodic = 1'b0; pause = 1'b0; cancel = 1'b0;

        add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        hold("idle_pause", 0, 0, 0);

        // One-shot N=3 P=0
        add("os3_load", 0, 1, 3, 0, 0, 0, 0, 1, 0, 3);
        idle("os3_e1", 1, 0, 2);
        idle("os3_e2", 1, 0, 1);
        idle("os3_e3", 0, 1, 0);
        idle("os3_e4", 0, 0, 0);

        // Prescale N=2 P=2; prescale input changed mid-run must be ignored
        add("ps_load", 0, 1, 2, 2, 0, 0, 0, 1, 0, 2);
        add("ps_e1", 0, 0, 9, 5, 1, 0, 0, 1, 0, 2);
        idle("ps_e2", 1, 0, 2);
        idle("ps_e3", 1, 0, 1);
        idle("ps_e4", 1, 0, 1);
        idle("ps_e5", 1, 0, 1);
        idle("ps_e6", 0, 1, 0);
        idle("ps_e7", 0, 0, 0);

        // Periodic N=4 P=0, cancel at edge 10
        add("per_load", 0, 1, 4, 0, 1, 0, 0, 1, 0, 4);
        idle("per_e1", 1, 0, 3);
        idle("per_e2", 1, 0, 2);
        idle("per_e3", 1, 0, 1);
        idle("per_e4", 1, 1, 4);
        idle("per_e5", 1, 0, 3);
        idle("per_e6", 1, 0, 2);
        idle("per_e7", 1, 0, 1);
        idle("per_e8", 1, 1, 4);
        idle("per_e9", 1, 0, 3);
        add("per_cancel", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle("per_e11", 0, 0, 0);
        idle("per_e12", 0, 0, 0);
        idle("per_e13", 0, 0, 0);

        // Pause N=5 P=1, pause over edges 3..7
        add("pz_load", 0, 1, 5, 1, 0, 0, 0, 1, 0, 5);
        idle("pz_e1", 1, 0, 5);
        idle("pz_e2", 1, 0, 4);
        for (int i = 3; i <= 7; i++) hold("pz_hold", 1, 0, 4);
        idle("pz_e8", 1, 0, 4);
        idle("pz_e9", 1, 0, 3);
        idle("pz_e10", 1, 0, 3);
        idle("pz_e11", 1, 0, 2);
        idle("pz_e12", 1, 0, 2);
        idle("pz_e13", 1, 0, 1);
        idle("pz_e14", 1, 0, 1);
        idle("pz_e15", 0, 1, 0);
        idle("pz_e16", 0, 0, 0);

        // Immediate expiry from IDLE and from RUN
        add("n0_idle", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle("n0_after", 0, 0, 0);
        add("n0r_load", 0, 1, 3, 0, 0, 0, 0, 1, 0, 3);
        add("n0r_reload", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle("n0r_after", 0, 0, 0);

        // Re-load N=2 at edge 2 of an N=3 run
        add("rl_load", 0, 1, 3, 0, 0, 0, 0, 1, 0, 3);
        idle("rl_e1", 1, 0, 2);
        add("rl_reload", 0, 1, 2, 0, 0, 0, 0, 1, 0, 2);
        idle("rl_e3", 1, 0, 1);
        idle("rl_e4", 0, 1, 0);
        idle("rl_e5", 0, 0, 0);

        // load+cancel together takes the load path
        add("lc_both", 0, 1, 2, 0, 0, 0, 1, 1, 0, 2);
        idle("lc_e1", 1, 0, 1);
        idle("lc_e2", 0, 1, 0);

        // load on a terminal tick wins, then cancel on a terminal tick wins
        add("lt_load", 0, 1, 2, 0, 0, 0, 0, 1, 0, 2);
        idle("lt_e1", 1, 0, 1);
        add("lt_reload", 0, 1, 3, 0, 0, 0, 0, 1, 0, 3);
        idle("lt_e3", 1, 0, 2);
        idle("lt_e4", 1, 0, 1);
        add("ct_cancel", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle("ct_after", 0, 0, 0);

        // Periodic N=1: expire every clock
        add("p1_load", 0, 1, 1, 0, 1, 0, 0, 1, 0, 1);
        idle("p1_e1", 1, 1, 1);
        idle("p1_e2", 1, 1, 1);
        add("p1_cancel", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        for (int unsigned i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Maximum prescale: P=255 gives 256 clocks per tick
        apply(mk("p255_load", 0, 1, 1, 8'hFF, 0, 0, 0, 1, 0, 1));
        for (int i = 1; i < 256; i++) apply(mk("p255_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        apply(mk("p255_exp", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        apply(mk("p255_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset mid-run of N=10, then confirm no later pulse
        apply(mk("rst_load", 0, 1, 10, 0, 0, 0, 0, 1, 0, 10));
        apply(mk("rst_e1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 9));
        apply(mk("rst_e2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 8));
        apply(mk("rst_mid", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++) apply(mk("rst_quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk("rst_vs_load", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer with prescaler, one-shot and periodic modes, and pause/cancel control. It is the counting-down counterpart to the free-running up-counter with terminal-count compare. Game logic loads a tick count and gets a single-cycle `expire` pulse when it runs out. Typical users are invader march cadence, shot cooldown, and explosion hold timers.

## Interface

**Parameters**
- `WIDTH`, default 16: width of the tick count and `remaining`.
- `PRESCALE_WIDTH`, default 8: width of the prescale field.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `load` in 1: arm or re-arm the timer with `load_value`. Level-sampled each clock.
- `load_value` in WIDTH: tick count N, captured when `load`=1.
- `prescale` in PRESCALE_WIDTH: P. One tick equals P+1 clocks. Captured when `load`=1.
- `periodic` in 1: 1 selects auto-reload mode, 0 selects one-shot. Captured when `load`=1.
- `pause` in 1: while high, freezes the prescaler and `remaining`.
- `cancel` in 1: stop the timer without expiring.
- `busy` out 1: high while in RUN.
- `expire` out 1: registered single-cycle pulse at countdown completion.
- `remaining` out WIDTH: ticks left in the current period.

## Operation

- **State and registers.**
  - States: IDLE and RUN.
  - Internal registers: `reload` (WIDTH), `p_lat` (PRESCALE_WIDTH), `per_lat`, and prescale counter `pc` (PRESCALE_WIDTH).
- **Reset.** State IDLE, `remaining`=0, `busy`=0, `expire`=0, `pc`=0, `reload`=0, `p_lat`=0, `per_lat`=0.
- **Priority, highest first:** `rst` > `load` > `cancel` > `pause` > tick step.
- **`load`=1 in any state:**
  - Captures `reload`←`load_value`, `p_lat`←`prescale`, `per_lat`←`periodic`, and clears `pc`←0.
  - If `load_value`≠0: `remaining`←`load_value`, go to RUN. This re-triggers a running timer and discards its progress; no `expire` is produced for the aborted period.
  - If `load_value`=0: `remaining`←0, stay in or go to IDLE, and `expire`←1 on that edge (immediate expiry).
- **`cancel`=1 without `load`:**
  - Go to IDLE, `remaining`←0, `pc`←0, no `expire`.
  - Has no effect in IDLE other than holding these values.
- **RUN with `pause`=1:** `pc` and `remaining` hold. `busy` stays 1.
- **RUN with `pause`=0:**
  - If `pc`≠`p_lat`: `pc`←`pc`+1.
  - Otherwise `pc`←0 and a tick step occurs.
- **Tick step:**
  - If `remaining`>1: `remaining`←`remaining`−1.
  - If `remaining`=1: `expire`←1, then:
    - `per_lat`=1: `remaining`←`reload` and stay in RUN.
    - `per_lat`=0: `remaining`←0 and go to IDLE.
- **`expire` default:** 0 on every edge not listed above.
- **Arithmetic and width rules:**
  - All counts are unsigned.
  - `remaining` never wraps below 0.
  - `pc` compares by equality against `p_lat`, so P=2^PRESCALE_WIDTH−1 is legal and gives 2^PRESCALE_WIDTH clocks per tick.
  - Changes on `prescale`, `periodic`, or `load_value` while running have no effect until the next `load`.

## Timing

- **`busy` relation:** `busy` is registered and equals (state==RUN).
- **One-shot latency.** Take `load` sampled at edge k with N≥1, P, and no pause.
  - `remaining`=N after edge k.
  - `remaining` decrements after edges k+(P+1), k+2(P+1), and so on.
  - `expire`=1 for exactly the one cycle following edge k+N(P+1).
  - In one-shot mode, `busy` falls on that same edge k+N(P+1).
- **Periodic mode:** `expire` pulses every N(P+1) clocks. `busy` stays 1 and `remaining` shows N immediately after each expiry edge.
- **Pause:** every clock with `pause`=1 while in RUN delays all subsequent events by exactly one clock.
- **Immediate expiry:** `load` with N=0 gives `expire`=1 in the cycle after edge k, with `busy` remaining 0.
- **`load` coinciding with a terminal tick step:** `load` wins. No `expire` is produced, and the new count starts.
- **`cancel` coinciding with a terminal tick step:** `cancel` wins. No `expire` is produced.

## Test plan

- **One-shot, N=3, P=0, one-cycle `load` at edge 0:**
  - `remaining` reads 3,2,1,0 after edges 0,1,2,3.
  - `expire` is high only in the cycle after edge 3.
  - `busy` is high after edges 0–2 and low after edge 3.
- **Prescale, N=2, P=2:**
  - `expire` is high only in the cycle after edge 6.
  - `remaining` changes 2→1 at edge 3.
- **Periodic, N=4, P=0:**
  - `expire` pulses after edges 4, 8, 12, and so on.
  - `remaining` sequence is 4,3,2,1,4,3…
  - `cancel` at edge 10 gives `busy`=0, `remaining`=0, and no pulse at 12.
- **Pause, N=5, P=1:** `pause` held for edges 3–7 (5 clocks) moves `expire` from the cycle after edge 10 to the cycle after edge 15.
- **Edge cases:**
  - `load` with N=0 gives a one-cycle `expire` with `busy`=0.
  - Re-`load` N=2 at edge 2 of an N=3 run gives no expire at 3, then `expire` after edge 4.
  - `load` and `cancel` in the same cycle follow the `load` path.
- **Reset mid-run:** `rst` asserted during an N=10 run gives `busy`=0, `remaining`=0, `expire`=0 on the next edge, with no later pulse.
